// File: rtl/canvas_pkg.sv
// Shared constants and FSM state type for the canvas frame-buffer write scheduler.
package canvas_pkg;

  localparam int unsigned DEF_H_PIXELS = 320;
  localparam int unsigned DEF_V_PIXELS = 180;
  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_COLOR_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStamp,
    StClear
  } state_e;

endpackage

// File: rtl/stamp_bounds.sv
// Clips a square brush of half-width r centred on (x, y) to the canvas edges.
module stamp_bounds #(
  parameter int unsigned H_PIXELS = 320,
  parameter int unsigned V_PIXELS = 180
) (
  input  logic [9:0] x_i,
  input  logic [8:0] y_i,
  input  logic [2:0] r_i,
  output logic [9:0] x_lo_o,
  output logic [9:0] x_hi_o,
  output logic [8:0] y_lo_o,
  output logic [8:0] y_hi_o,
  output logic       out_of_range_o
);

  logic [10:0] x_sum;
  logic [9:0]  y_sum;

  always_comb begin
    // One extra bit so x+r / y+r cannot wrap before clipping.
    x_sum  = {1'b0, x_i} + {8'b0, r_i};
    y_sum  = {1'b0, y_i} + {7'b0, r_i};
    x_lo_o = (x_i >= {7'b0, r_i}) ? (x_i - {7'b0, r_i}) : '0;
    y_lo_o = (y_i >= {6'b0, r_i}) ? (y_i - {6'b0, r_i}) : '0;
    x_hi_o = (x_sum > 11'(H_PIXELS - 1)) ? 10'(H_PIXELS - 1) : x_sum[9:0];
    y_hi_o = (y_sum > 10'(V_PIXELS - 1)) ? 9'(V_PIXELS - 1) : y_sum[8:0];
    out_of_range_o = (x_i >= 10'(H_PIXELS)) || (y_i >= 9'(V_PIXELS));
  end

endmodule

// File: rtl/canvas_write_ctrl.sv
// Arbitrates canvas clear and brush stamp requests onto a single one-pixel-per-cycle
// frame-buffer write port. Clear wins in IDLE; neither preempts the other.
module canvas_write_ctrl
  import canvas_pkg::*;
#(
  parameter int unsigned H_PIXELS = DEF_H_PIXELS,
  parameter int unsigned V_PIXELS = DEF_V_PIXELS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned COLOR_W  = DEF_COLOR_W
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [9:0]         x_in,
  input  logic [8:0]         y_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic [2:0]         sw_in,
  input  logic               pen_in,
  input  logic               nf_in,
  input  logic               clear_in,
  input  logic [COLOR_W-1:0] bg_color_in,
  output logic               wr_en_out,
  output logic [ADDR_W-1:0]  wr_addr_out,
  output logic [COLOR_W-1:0] wr_data_out,
  output logic               busy_out,
  output logic               stamp_done_out,
  output logic               clear_done_out
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(H_PIXELS * V_PIXELS - 1);
  localparam logic [ADDR_W-1:0] RowStep  = ADDR_W'(H_PIXELS);

  state_e state_q, state_d;

  logic               stamp_pend_q, stamp_pend_d;
  logic               clear_pend_q, clear_pend_d;
  logic [9:0]         lx_q, lx_d;
  logic [8:0]         ly_q, ly_d;
  logic [2:0]         lr_q, lr_d;
  logic [COLOR_W-1:0] lcol_q, lcol_d;
  logic [COLOR_W-1:0] bg_q, bg_d;

  logic [9:0]         x_lo_q, x_lo_d;
  logic [9:0]         x_hi_q, x_hi_d;
  logic [8:0]         y_hi_q, y_hi_d;
  logic [9:0]         cur_x_q, cur_x_d;
  logic [8:0]         cur_y_q, cur_y_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic [COLOR_W-1:0] scol_q, scol_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;

  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [COLOR_W-1:0] wr_data_q, wr_data_d;
  logic               busy_q, busy_d;
  logic               stamp_done_q, stamp_done_d;
  logic               clear_done_q, clear_done_d;

  logic [9:0] b_x_lo, b_x_hi;
  logic [8:0] b_y_lo, b_y_hi;
  logic       b_oor;

  stamp_bounds #(
    .H_PIXELS(H_PIXELS),
    .V_PIXELS(V_PIXELS)
  ) u_bounds (
    .x_i           (lx_q),
    .y_i           (ly_q),
    .r_i           (lr_q),
    .x_lo_o        (b_x_lo),
    .x_hi_o        (b_x_hi),
    .y_lo_o        (b_y_lo),
    .y_hi_o        (b_y_hi),
    .out_of_range_o(b_oor)
  );

  always_comb begin
    state_d      = state_q;
    stamp_pend_d = stamp_pend_q;
    clear_pend_d = clear_pend_q;
    lx_d         = lx_q;
    ly_d         = ly_q;
    lr_d         = lr_q;
    lcol_d       = lcol_q;
    bg_d         = bg_q;
    x_lo_d       = x_lo_q;
    x_hi_d       = x_hi_q;
    y_hi_d       = y_hi_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    row_base_d   = row_base_q;
    scol_d       = scol_q;
    cnt_d        = cnt_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    stamp_done_d = 1'b0;
    clear_done_d = 1'b0;

    if (nf_in && pen_in) begin
      stamp_pend_d = 1'b1;
      lx_d         = x_in;
      ly_d         = y_in;
      lr_d         = sw_in;
      lcol_d       = color_in;
    end
    // A clear request during a running clear merges into it.
    if (clear_in && (state_q != StClear)) begin
      clear_pend_d = 1'b1;
      bg_d         = bg_color_in;
    end

    unique case (state_q)
      StIdle: begin
        // Uses the _d flags so a request arriving this edge is taken immediately.
        if (clear_pend_d) begin
          clear_pend_d = 1'b0;
          cnt_d        = '0;
          state_d      = StClear;
        end else if (stamp_pend_d) begin
          stamp_pend_d = 1'b0;
          state_d      = StSetup;
        end
      end
      StSetup: begin
        if (b_oor) begin
          state_d = StIdle;
        end else begin
          x_lo_d     = b_x_lo;
          x_hi_d     = b_x_hi;
          y_hi_d     = b_y_hi;
          cur_x_d    = b_x_lo;
          cur_y_d    = b_y_lo;
          row_base_d = ADDR_W'(b_y_lo) * RowStep;
          scol_d     = lcol_q;
          state_d    = StStamp;
        end
      end
      StStamp: begin
        wr_en_d   = 1'b1;
        wr_addr_d = row_base_q + ADDR_W'(cur_x_q);
        wr_data_d = scol_q;
        if (cur_x_q == x_hi_q) begin
          cur_x_d    = x_lo_q;
          cur_y_d    = cur_y_q + 9'd1;
          row_base_d = row_base_q + RowStep;
          if (cur_y_q == y_hi_q) begin
            stamp_done_d = 1'b1;
            state_d      = StIdle;
          end
        end else begin
          cur_x_d = cur_x_q + 10'd1;
        end
      end
      StClear: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = bg_q;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == LastAddr) begin
          clear_done_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Busy also covers the registered final write after the FSM has returned to IDLE.
    busy_d = (state_d != StIdle) || wr_en_d;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= StIdle;
      stamp_pend_q <= 1'b0;
      clear_pend_q <= 1'b0;
      lx_q         <= '0;
      ly_q         <= '0;
      lr_q         <= '0;
      lcol_q       <= '0;
      bg_q         <= '0;
      x_lo_q       <= '0;
      x_hi_q       <= '0;
      y_hi_q       <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      row_base_q   <= '0;
      scol_q       <= '0;
      cnt_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      stamp_done_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stamp_pend_q <= stamp_pend_d;
      clear_pend_q <= clear_pend_d;
      lx_q         <= lx_d;
      ly_q         <= ly_d;
      lr_q         <= lr_d;
      lcol_q       <= lcol_d;
      bg_q         <= bg_d;
      x_lo_q       <= x_lo_d;
      x_hi_q       <= x_hi_d;
      y_hi_q       <= y_hi_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      row_base_q   <= row_base_d;
      scol_q       <= scol_d;
      cnt_q        <= cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      stamp_done_q <= stamp_done_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign wr_en_out      = wr_en_q;
  assign wr_addr_out    = wr_addr_q;
  assign wr_data_out    = wr_data_q;
  assign busy_out       = busy_q;
  assign stamp_done_out = stamp_done_q;
  assign clear_done_out = clear_done_q;

endmodule
